// File: rtl/clk_meter_pkg.sv
// -----------------------------------------------------------------------------
// clk_meter_pkg
//   Shared types for the divided-clock meter.
//   Contents:
//     meter_state_e  - measurement FSM state encoding
//     SYNC_MIN       - smallest synchronizer depth that is metastability-safe
// -----------------------------------------------------------------------------
package clk_meter_pkg;

  typedef enum logic [1:0] {
    WAIT_EDGE = 2'd0,  // out of reset: waiting for the first edge
    MEASURE   = 2'd1,  // publishing periods, not yet locked
    LOCKED    = 2'd2,  // LOCK_CNT consecutive matching periods seen
    STUCK     = 2'd3   // no rising edge for a full counter range
  } meter_state_e;

  localparam int SYNC_MIN = 2;

endpackage : clk_meter_pkg

// File: rtl/sync_rise_det.sv
// -----------------------------------------------------------------------------
// sync_rise_det
//   Brings an asynchronous level into the clk domain through a flop chain and
//   produces a one-cycle pulse on each synchronized rising edge.
//   Ports:
//     clk       in   master clock, posedge
//     rst       in   asynchronous active-low reset
//     async_in  in   asynchronous level to be sampled
//     sync_out  out  synchronized level (last chain stage)
//     rise      out  1 for the single cycle in which sync_out first reads 1
// -----------------------------------------------------------------------------
module sync_rise_det
  import clk_meter_pkg::*;
#(
  parameter int SYNC_STAGES = 2  // must be >= SYNC_MIN
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   s_dly_q;
  logic                   s_dly_d;

  // Shift the raw input into stage 0; the extra delay flop gives edge detect.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], async_in};
    s_dly_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '0;
      s_dly_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      s_dly_q <= s_dly_d;
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign rise     = sync_q[SYNC_STAGES-1] & ~s_dly_q;

endmodule : sync_rise_det

// File: rtl/clk_div_meter.sv
// -----------------------------------------------------------------------------
// clk_div_meter
//   On-chip checker for clock dividers. Measures the period and high time of
//   div_in in clk cycles, checks the duty cycle, flags periods that differ
//   from exp_period, declares lock after LOCK_CNT consecutive matches and
//   flags a stalled divider.
//   Ports:
//     clk         in   master clock, posedge
//     rst         in   asynchronous active-low reset
//     div_in      in   divided clock under test (asynchronous)
//     exp_period  in   expected period in clk cycles (quasi-static)
//     period      out  last measured period
//     high_time   out  high samples in that period
//     meas_valid  out  1-cycle pulse when period/high_time update
//     duty_ok     out  |2*high_time - period| <= 1 for the last measurement
//     mismatch    out  1-cycle pulse when a measured period != exp_period
//     locked      out  LOCK_CNT consecutive matching periods
//     stuck       out  no rising edge for 2**CNT_W-1 cycles
// -----------------------------------------------------------------------------
module clk_div_meter
  import clk_meter_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int LOCK_CNT    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_in,
  input  logic [CNT_W-1:0] exp_period,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             duty_ok,
  output logic             mismatch,
  output logic             locked,
  output logic             stuck
);

  localparam int               MC_W     = $clog2(LOCK_CNT + 1);
  localparam logic [MC_W-1:0]  LOCK_VAL = MC_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // ---------------------------------------------------------------------------
  // Synchronizer and edge detect
  // ---------------------------------------------------------------------------
  logic s;
  logic rise;

  sync_rise_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (div_in),
    .sync_out (s),
    .rise     (rise)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  meter_state_e     state_q,      state_d;
  logic [CNT_W-1:0] cyc_cnt_q,    cyc_cnt_d;
  logic [CNT_W-1:0] hi_cnt_q,     hi_cnt_d;
  logic [CNT_W-1:0] period_q,     period_d;
  logic [CNT_W-1:0] high_time_q,  high_time_d;
  logic             meas_valid_q, meas_valid_d;
  logic             duty_ok_q,    duty_ok_d;
  logic             mismatch_q,   mismatch_d;
  logic             locked_q,     locked_d;
  logic             stuck_q,      stuck_d;
  logic [MC_W-1:0]  match_cnt_q,  match_cnt_d;

  // ---------------------------------------------------------------------------
  // Free-running period / high-time counters
  // ---------------------------------------------------------------------------
  logic cyc_sat;
  logic hi_sat;

  always_comb begin
    cyc_sat = (cyc_cnt_q == CNT_MAX);
    hi_sat  = (hi_cnt_q == CNT_MAX);

    // The rise cycle is the first cycle of the new period, so it counts as 1.
    if (rise) begin
      cyc_cnt_d = CNT_W'(1);
    end else if (cyc_sat) begin
      cyc_cnt_d = cyc_cnt_q;
    end else begin
      cyc_cnt_d = cyc_cnt_q + 1'b1;
    end

    // s is always high in the rise cycle, so that sample opens the high count;
    // high_time then equals the number of high samples in the period.
    if (rise) begin
      hi_cnt_d = CNT_W'(1);
    end else if (s && !hi_sat) begin
      hi_cnt_d = hi_cnt_q + 1'b1;
    end else begin
      hi_cnt_d = hi_cnt_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Duty and period comparison on the counts about to be captured
  // ---------------------------------------------------------------------------
  logic [CNT_W:0] twice_hi;
  logic [CNT_W:0] per_ext;
  logic [CNT_W:0] duty_diff;
  logic           duty_now;
  logic           period_match;

  always_comb begin
    // One extra bit so 2*hi_cnt cannot overflow.
    twice_hi  = {hi_cnt_q, 1'b0};
    per_ext   = {1'b0, cyc_cnt_q};
    duty_diff = (twice_hi >= per_ext) ? (twice_hi - per_ext) : (per_ext - twice_hi);
    duty_now  = (duty_diff <= (CNT_W + 1)'(1));
    // A zero expectation is treated as "no valid target": it never matches.
    period_match = (cyc_cnt_q == exp_period) && (exp_period != '0);
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and output computation
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    period_d     = period_q;
    high_time_d  = high_time_q;
    meas_valid_d = 1'b0;
    duty_ok_d    = duty_ok_q;
    mismatch_d   = 1'b0;
    locked_d     = locked_q;
    stuck_d      = stuck_q;
    match_cnt_d  = match_cnt_q;

    unique case (state_q)
      WAIT_EDGE: begin
        // The period in flight at reset release is partial: discard it.
        if (rise) begin
          state_d = MEASURE;
        end else if (cyc_sat) begin
          state_d     = STUCK;
          stuck_d     = 1'b1;
          locked_d    = 1'b0;
          match_cnt_d = '0;
        end
      end

      MEASURE, LOCKED: begin
        // A rise in the saturation cycle still counts as a valid edge.
        if (rise) begin
          period_d     = cyc_cnt_q;
          high_time_d  = hi_cnt_q;
          meas_valid_d = 1'b1;
          duty_ok_d    = duty_now;
          if (period_match) begin
            match_cnt_d = (match_cnt_q == LOCK_VAL) ? LOCK_VAL : match_cnt_q + 1'b1;
            if (match_cnt_d == LOCK_VAL) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end
          end else begin
            match_cnt_d = '0;
            mismatch_d  = 1'b1;
            locked_d    = 1'b0;
            state_d     = MEASURE;
          end
        end else if (cyc_sat) begin
          state_d     = STUCK;
          stuck_d     = 1'b1;
          locked_d    = 1'b0;
          match_cnt_d = '0;
        end
      end

      STUCK: begin
        // This edge only restarts the period counter; nothing is published.
        if (rise) begin
          state_d = MEASURE;
          stuck_d = 1'b0;
        end
      end

      default: begin
        state_d = WAIT_EDGE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= WAIT_EDGE;
      cyc_cnt_q    <= '0;
      hi_cnt_q     <= '0;
      period_q     <= '0;
      high_time_q  <= '0;
      meas_valid_q <= 1'b0;
      duty_ok_q    <= 1'b0;
      mismatch_q   <= 1'b0;
      locked_q     <= 1'b0;
      stuck_q      <= 1'b0;
      match_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      cyc_cnt_q    <= cyc_cnt_d;
      hi_cnt_q     <= hi_cnt_d;
      period_q     <= period_d;
      high_time_q  <= high_time_d;
      meas_valid_q <= meas_valid_d;
      duty_ok_q    <= duty_ok_d;
      mismatch_q   <= mismatch_d;
      locked_q     <= locked_d;
      stuck_q      <= stuck_d;
      match_cnt_q  <= match_cnt_d;
    end
  end

  assign period     = period_q;
  assign high_time  = high_time_q;
  assign meas_valid = meas_valid_q;
  assign duty_ok    = duty_ok_q;
  assign mismatch   = mismatch_q;
  assign locked     = locked_q;
  assign stuck      = stuck_q;

endmodule : clk_div_meter
